// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter: digit width,
// 7-segment codes, and integer-to-BCD conversion for parameter constants.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned MAX_DIG = 8;

  // Index d holds the active-high a..g code of decimal digit d; dp stays 0.
  localparam logic [9:0][SEG_W-1:0] SEG_CODES = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] nib);
    logic [SEG_W-1:0] code;
    code = '0;
    if (nib <= 4'd9) code = SEG_CODES[nib];
    return code;
  endfunction

  function automatic logic [DIGIT_W*MAX_DIG-1:0] to_bcd(input int unsigned value);
    logic [DIGIT_W*MAX_DIG-1:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < int'(MAX_DIG); i++) begin
      r[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count as a tick.
module tick_gen #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Gated by en so a paused counter parked on the last value cannot repeat the tick.
  assign tick = en & w_last;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with terminal wrap, prescaled count tick
// and a multiplexed 7-segment display scan.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned MOD_MAX  = 19,
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up,
  input  logic                        clr,
  output logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        wrap,
  output logic [SEG_W-1:0]            seg,
  output logic [DIGITS-1:0]           cat
);

  localparam int unsigned BCD_W  = DIGIT_W * DIGITS;
  localparam int unsigned SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SDIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [BCD_W-1:0] MOD_BCD = BCD_W'(to_bcd(MOD_MAX));

  logic [BCD_W-1:0]   r_bcd;
  logic               r_wrap;
  logic [SCAN_W-1:0]  r_scan;
  logic [SDIV_W-1:0]  r_sdiv;
  logic [SEG_W-1:0]   r_seg;
  logic [DIGITS-1:0]  r_cat;

  logic               w_tick;
  logic [BCD_W-1:0]   w_inc;
  logic [BCD_W-1:0]   w_dec;
  logic [DIGIT_W-1:0] w_digit;
  logic [DIGITS-1:0]  w_cat;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .tick (w_tick)
  );

  // Decimal +1 / -1 with ripple carry/borrow across digits.
  always_comb begin
    logic carry;
    logic borrow;
    carry  = 1'b1;
    borrow = 1'b1;
    w_inc  = r_bcd;
    w_dec  = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (r_bcd[DIGIT_W*i +: DIGIT_W] >= 4'd9) begin
          w_inc[DIGIT_W*i +: DIGIT_W] = 4'd0;
        end else begin
          w_inc[DIGIT_W*i +: DIGIT_W] = r_bcd[DIGIT_W*i +: DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (r_bcd[DIGIT_W*i +: DIGIT_W] == 4'd0) begin
          w_dec[DIGIT_W*i +: DIGIT_W] = 4'd9;
        end else begin
          w_dec[DIGIT_W*i +: DIGIT_W] = r_bcd[DIGIT_W*i +: DIGIT_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clr) begin
        r_bcd <= '0;
      end else if (w_tick) begin
        if (up) begin
          if (r_bcd == MOD_BCD) begin
            r_bcd  <= '0;
            r_wrap <= 1'b1;
          end else begin
            r_bcd <= w_inc;
          end
        end else begin
          if (r_bcd == '0) begin
            r_bcd  <= MOD_BCD;
            r_wrap <= 1'b1;
          end else begin
            r_bcd <= w_dec;
          end
        end
      end
    end
  end

  // Digit mux and one-cold select for the current scan index.
  always_comb begin
    w_digit = '0;
    w_cat   = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_scan == SCAN_W'(i)) begin
        w_digit  = r_bcd[DIGIT_W*i +: DIGIT_W];
        w_cat[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_sdiv <= '0;
      r_seg  <= '0;
      r_cat  <= '1;
    end else begin
      r_seg <= seg_encode(w_digit);
      r_cat <= w_cat;
      if (r_sdiv == SDIV_W'(SCAN_DIV - 1)) begin
        r_sdiv <= '0;
        r_scan <= (r_scan == SCAN_W'(DIGITS - 1)) ? '0 : r_scan + SCAN_W'(1);
      end else begin
        r_sdiv <= r_sdiv + SDIV_W'(1);
      end
    end
  end

  assign bcd  = r_bcd;
  assign wrap = r_wrap;
  assign seg  = r_seg;
  assign cat  = r_cat;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DIGITS=2, MOD_MAX=19, TICK_DIV=4, SCAN_DIV=1.
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic [7:0] bcd;
  logic       wrap;
  logic [7:0] seg;
  logic [1:0] cat;

  int n_checks;
  int n_errors;

  bcd_updown_counter #(
    .DIGITS   (2),
    .MOD_MAX  (19),
    .TICK_DIV (4),
    .SCAN_DIV (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .clr  (clr),
    .bcd  (bcd),
    .wrap (wrap),
    .seg  (seg),
    .cat  (cat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] up_exp [20] = '{
    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10,
    8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h00
  };
  logic [7:0] dn_exp [15] = '{
    8'h19, 8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12,
    8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05
  };

  initial begin
    logic [1:0] exp_cat;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;

    #12;
    check("rst_bcd",  32'(bcd),  32'h00);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_seg",  32'(seg),  32'h00);
    check("rst_cat",  32'(cat),  32'h3);

    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; up = 1'b1;

    // Up count through MOD_MAX and back to zero.
    for (int t = 0; t < 20; t++) begin
      step(3);
      check("up_pre", 32'(bcd), (t == 0) ? 32'h00 : 32'(up_exp[t-1]));
      step(1);
      check("up_bcd",  32'(bcd),  32'(up_exp[t]));
      check("up_wrap", 32'(wrap), (t == 19) ? 32'h1 : 32'h0);
    end
    step(1);
    check("up_wrap_end", 32'(wrap), 32'h0);
    check("up_hold0",    32'(bcd),  32'h00);

    // Direction change mid-period applies at the next tick; down from zero wraps to 19.
    up = 1'b0;
    for (int t = 0; t < 15; t++) begin
      step((t == 0) ? 3 : 4);
      check("dn_bcd",  32'(bcd),  32'(dn_exp[t]));
      check("dn_wrap", 32'(wrap), (t == 0) ? 32'h1 : 32'h0);
    end

    // Pause at 0x05 with one prescaler cycle already consumed.
    step(1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("pause_hold", 32'(bcd), 32'h05);
    end
    en = 1'b1;
    step(2);
    check("resume_early", 32'(bcd), 32'h05);
    step(1);
    check("resume_tick", 32'(bcd), 32'h04);

    // Plain clear, then reach 0x19 by down-wrap.
    clr = 1'b1;
    step(1);
    check("clr_bcd", 32'(bcd), 32'h00);
    clr = 1'b0;
    step(4);
    check("pre19_bcd",  32'(bcd),  32'h19);
    check("pre19_wrap", 32'(wrap), 32'h1);

    // Clear coincident with the tick wins and suppresses wrap.
    step(3);
    clr = 1'b1;
    step(1);
    check("clrtick_bcd",  32'(bcd),  32'h00);
    check("clrtick_wrap", 32'(wrap), 32'h0);
    clr = 1'b0;
    step(1);
    check("clrtick_wrap2", 32'(wrap), 32'h0);
    check("clrtick_bcd2",  32'(bcd),  32'h00);

    // Down to 0x17 (19, 18, 17) then freeze for the scan check.
    step(3);
    check("to17_a", 32'(bcd), 32'h19);
    step(4);
    step(4);
    check("to17_b", 32'(bcd), 32'h17);
    en = 1'b0;
    step(2);
    exp_cat = (cat == 2'b10) ? 2'b10 : 2'b01;
    for (int i = 0; i < 6; i++) begin
      check("scan_cat", 32'(cat), 32'(exp_cat));
      check("scan_seg", 32'(seg), (exp_cat == 2'b10) ? 32'h07 : 32'h06);
      exp_cat = ~exp_cat;
      step(1);
    end

    // Asynchronous reset mid-scan, observed without any clock edge.
    rst = 1'b1;
    #1;
    check("arst_cat",  32'(cat),  32'h3);
    check("arst_seg",  32'(seg),  32'h00);
    check("arst_bcd",  32'(bcd),  32'h00);
    check("arst_wrap", 32'(wrap), 32'h0);
    step(1);
    rst = 1'b0; en = 1'b1; up = 1'b1;

    // Prescaler restarts from zero after reset.
    step(3);
    check("post_rst_pre", 32'(bcd), 32'h00);
    step(1);
    check("post_rst_tick", 32'(bcd), 32'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
